hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Producer-side companion to the EX-stage forwarding logic in the 5-stage pipelined CPU with interrupts.
- Handles the hazards that forwarding cannot cover: load-use stalls, data-memory wait freezes, branch flushes, and interrupt entry by draining the pipeline.
- Drives the write-enable and flush controls of the PC and every pipeline register.
- Holds a small control FSM, a drain counter, a memory-wait timeout counter and a stall performance counter.

Parameters:
- DRAIN_CYCLES, 3, bubbles injected before the interrupt is taken (ID/EX/MEM retire).
- MEM_TIMEOUT, 15, maximum consecutive dmem_ready-low cycles before the block forces progress.
- CNT_W, 16, stall_count width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ID_rs1  in  5  source register 1 of the instruction in ID.
- ID_rs2  in  5  source register 2 of the instruction in ID.
- ID_use_rs1  in  1  ID instruction reads rs1.
- ID_use_rs2  in  1  ID instruction reads rs2.
- EX_rd  in  5  destination register of the instruction in EX.
- EX_MemRead  in  1  EX instruction is a load.
- MEM_MemAccess  in  1  MEM instruction is a load or store.
- dmem_ready  in  1  data memory completes the access this cycle.
- EX_branch_taken  in  1  EX resolved a taken branch or jump.
- irq_req  in  1  level interrupt request, held until irq_take.
- PC_Write  out  1  PC update enable.
- IFID_Write  out  1  IF/ID register enable.
- IFID_Flush  out  1  IF/ID register loads a NOP.
- IDEX_Flush  out  1  ID/EX register loads a bubble.
- IDEX_Write  out  1  ID/EX register enable.
- EXMEM_Write  out  1  EX/MEM register enable.
- MEMWB_Flush  out  1  MEM/WB register loads a bubble.
- irq_take  out  1  one-cycle pulse: CSR saves the PC as EPC and the PC loads the vector.
- mem_timeout  out  1  sticky error flag; cleared only by reset.
- stall_count  out  CNT_W  saturating count of cycles with PC_Write=0.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=RUN; all counters 0; mem_timeout=0.
  - While rst_n is low: all *_Write=0, all *_Flush=0, irq_take=0.
  - After rst_n rises, outputs follow the decoded RUN values below.
- FSM states: RUN, MEM_WAIT, DRAIN, IRQ_ENTER.
- Output values are decoded combinationally from state and inputs. Defaults: every Write=1, every Flush=0, irq_take=0.
- Input conditions:
  - mw = MEM_MemAccess & ~dmem_ready.
  - lu = EX_MemRead & EX_rd!=0 & ((ID_use_rs1 & ID_rs1==EX_rd) | (ID_use_rs2 & ID_rs2==EX_rd)).
- Priority within RUN: mw > EX_branch_taken > lu > irq_req.
- RUN, mw:
  - Freeze: PC, IFID, IDEX and EXMEM Write=0; MEMWB_Flush=1.
  - Next state MEM_WAIT; wait counter=1.
- RUN, branch (no mw): IFID_Flush=1, IDEX_Flush=1, PC_Write=1. lu is ignored because the dependent instruction is squashed.
- RUN, lu (no mw, no branch):
  - PC_Write=0, IFID_Write=0, IDEX_Flush=1 for exactly one cycle; stay in RUN.
  - Next cycle the load is in MEM and lu deasserts.
- RUN, irq_req (no other condition):
  - PC_Write=0, IFID_Flush=1.
  - Next state DRAIN; drain counter=1.
- MEM_WAIT:
  - Freeze outputs as above while dmem_ready=0; wait counter increments each cycle.
  - dmem_ready=1: release the freeze (defaults this cycle); next state RUN, or DRAIN if irq_req=1.
  - Wait counter reaches MEM_TIMEOUT: set mem_timeout; release exactly as if dmem_ready=1.
- DRAIN:
  - PC_Write=0 and IFID_Flush=1 each cycle; counter increments.
  - mw inside DRAIN: apply the freeze and pause the counter; remain in DRAIN.
  - EX_branch_taken inside DRAIN: PC_Write=1 for that cycle (redirect), IDEX_Flush=1; counter continues.
  - Counter == DRAIN_CYCLES: next state IRQ_ENTER.
- IRQ_ENTER:
  - irq_take=1, PC_Write=1, IFID_Flush=1 for one cycle.
  - Next state RUN. irq_req still high in RUN re-arms the interrupt path only on the next cycle.
- stall_count: +1 on each cycle with PC_Write=0 while rst_n=1; saturates at all-ones, no wrap.
- Register x0 never causes a load-use stall.

Decomposition:
- Shared package cpu_ctrl_pkg:
  - FSM state encoding: RUN=2'd0, MEM_WAIT=2'd1, DRAIN=2'd2, IRQ_ENTER=2'd3.
  - REG_X0 constant.
  - Default MEM_TIMEOUT and DRAIN_CYCLES values.
- One natural sub-module: hazard_sat_counter, the parameterised saturating counter used for stall_count (and reusable for the wait counter).

Test Plan:
- EX_MemRead=1, EX_rd=5, ID_rs2=5, ID_use_rs2=1 -> one cycle of PC_Write=0, IFID_Write=0, IDEX_Flush=1; defaults next cycle; stall_count=1.
- Same as above with EX_rd=0, or with ID_use_rs2=0 -> no stall; stall_count stays 0.
- lu and EX_branch_taken in the same cycle -> IFID_Flush=1, IDEX_Flush=1, PC_Write=1, no stall.
- MEM_MemAccess=1 with dmem_ready low for 4 cycles -> 4 freeze cycles with MEMWB_Flush=1; release on the 5th cycle; mem_timeout=0. With dmem_ready held low for MEM_TIMEOUT=15 cycles -> release, mem_timeout=1 and stays set.
- irq_req=1 in idle RUN -> 1+DRAIN_CYCLES cycles of IFID_Flush=1 and PC_Write=0, then a single irq_take pulse, then RUN. Repeat with dmem_ready low for 2 cycles mid-drain -> irq_take is delayed by exactly 2 cycles.
- Assert rst_n=0 mid-DRAIN -> outputs immediately take reset values; after release, state=RUN and no irq_take appears until irq_req is sampled again.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared pipeline-control definitions: hazard FSM encoding, register constants and the
// load-use detector used by the stall unit.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StMemWait  = 2'd1,
        StDrain    = 2'd2,
        StIrqEnter = 2'd3
    } hz_state_e;

    localparam logic [4:0] REG_X0 = 5'd0;

    localparam int unsigned DefMemTimeout  = 15;
    localparam int unsigned DefDrainCycles = 3;

    // x0 is hardwired to zero, so a load targeting it can never feed a consumer.
    function automatic logic load_use_hit(
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       use_rs1,
        input logic       use_rs2,
        input logic [4:0] ex_rd,
        input logic       ex_memread
    );
        return ex_memread && (ex_rd != REG_X0) &&
               ((use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd)));
    endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Pipeline-side bundle of the hazard/stall unit: hazard sources in, register controls out.
interface hazard_stall_unit_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       ID_rs1;
    logic [4:0]       ID_rs2;
    logic             ID_use_rs1;
    logic             ID_use_rs2;
    logic [4:0]       EX_rd;
    logic             EX_MemRead;
    logic             MEM_MemAccess;
    logic             dmem_ready;
    logic             EX_branch_taken;
    logic             irq_req;
    logic             PC_Write;
    logic             IFID_Write;
    logic             IFID_Flush;
    logic             IDEX_Flush;
    logic             IDEX_Write;
    logic             EXMEM_Write;
    logic             MEMWB_Flush;
    logic             irq_take;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, EX_rd, EX_MemRead, MEM_MemAccess,
               dmem_ready, EX_branch_taken, irq_req,
        input  PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, IDEX_Write, EXMEM_Write,
               MEMWB_Flush, irq_take, mem_timeout, stall_count
    );

    modport slave (
        input  ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, EX_rd, EX_MemRead, MEM_MemAccess,
               dmem_ready, EX_branch_taken, irq_req,
        output PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, IDEX_Write, EXMEM_Write,
               MEMWB_Flush, irq_take, mem_timeout, stall_count
    );
endinterface

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter with synchronous clear; clear and increment together load one.
module hazard_sat_counter #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] count_o
);
    logic [Width-1:0] count_d, count_q;

    always_comb begin
        count_d = clr_i ? '0 : count_q;
        if (inc_i && (count_d != '1)) begin
            count_d = count_d + Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard controller: load-use stalls, data-memory freezes, branch flushes and
// interrupt entry by draining the pipeline.
module hazard_stall_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = DefDrainCycles,
    parameter int unsigned MEM_TIMEOUT  = DefMemTimeout,
    parameter int unsigned CNT_W        = 16
) (
    input logic                clk,
    input logic                rst_n,
    hazard_stall_unit_if.slave hz
);
    localparam int unsigned WaitW  = $clog2(MEM_TIMEOUT + 1);
    localparam int unsigned DrainW = $clog2(DRAIN_CYCLES + 1);

    hz_state_e state_d, state_q;
    logic mem_timeout_d, mem_timeout_q;
    logic mw, lu;
    logic pc_write, ifid_write, ifid_flush, idex_flush, idex_write, exmem_write, memwb_flush;
    logic irq_take, timeout_set;
    logic wait_clr, wait_inc, drain_clr, drain_inc;
    logic [WaitW-1:0]  wait_cnt;
    logic [DrainW-1:0] drain_cnt;
    logic [CNT_W-1:0]  stall_cnt;

    assign mw = hz.MEM_MemAccess & ~hz.dmem_ready;
    assign lu = load_use_hit(hz.ID_rs1, hz.ID_rs2, hz.ID_use_rs1, hz.ID_use_rs2,
                             hz.EX_rd, hz.EX_MemRead);

    always_comb begin
        state_d     = state_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        idex_write  = 1'b1;
        exmem_write = 1'b1;
        memwb_flush = 1'b0;
        irq_take    = 1'b0;
        timeout_set = 1'b0;
        wait_clr    = 1'b0;
        wait_inc    = 1'b0;
        drain_clr   = 1'b0;
        drain_inc   = 1'b0;

        case (state_q)
            StRun: begin
                if (mw) begin
                    {pc_write, ifid_write, idex_write, exmem_write} = 4'b0000;
                    memwb_flush = 1'b1;
                    wait_clr    = 1'b1;
                    wait_inc    = 1'b1;
                    state_d     = StMemWait;
                end else if (hz.EX_branch_taken) begin
                    // The dependent instruction is squashed, so a pending load-use is moot.
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (lu) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                end else if (hz.irq_req) begin
                    pc_write   = 1'b0;
                    ifid_flush = 1'b1;
                    drain_clr  = 1'b1;
                    drain_inc  = 1'b1;
                    state_d    = StDrain;
                end
            end
            StMemWait: begin
                if (hz.dmem_ready || (wait_cnt == WaitW'(MEM_TIMEOUT))) begin
                    timeout_set = ~hz.dmem_ready;
                    if (hz.irq_req) begin
                        drain_clr = 1'b1;
                        drain_inc = 1'b1;
                        state_d   = StDrain;
                    end else begin
                        state_d = StRun;
                    end
                end else begin
                    {pc_write, ifid_write, idex_write, exmem_write} = 4'b0000;
                    memwb_flush = 1'b1;
                    wait_inc    = 1'b1;
                end
            end
            StDrain: begin
                if (mw) begin
                    // Freeze pauses the drain count so retiring instructions are not lost.
                    {pc_write, ifid_write, idex_write, exmem_write} = 4'b0000;
                    memwb_flush = 1'b1;
                end else begin
                    pc_write   = hz.EX_branch_taken;
                    idex_flush = hz.EX_branch_taken;
                    ifid_flush = 1'b1;
                    drain_inc  = 1'b1;
                    if (drain_cnt == DrainW'(DRAIN_CYCLES)) begin
                        state_d = StIrqEnter;
                    end
                end
            end
            StIrqEnter: begin
                irq_take   = 1'b1;
                ifid_flush = 1'b1;
                state_d    = StRun;
            end
            default: state_d = StRun;
        endcase

        if (!rst_n) begin
            {pc_write, ifid_write, idex_write, exmem_write} = 4'b0000;
            {ifid_flush, idex_flush, memwb_flush, irq_take} = 4'b0000;
        end
    end

    assign mem_timeout_d = mem_timeout_q | timeout_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StRun;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    hazard_sat_counter #(.Width(WaitW)) u_wait_cnt (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .clr_i  (wait_clr),
        .inc_i  (wait_inc),
        .count_o(wait_cnt)
    );

    hazard_sat_counter #(.Width(DrainW)) u_drain_cnt (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .clr_i  (drain_clr),
        .inc_i  (drain_inc),
        .count_o(drain_cnt)
    );

    hazard_sat_counter #(.Width(CNT_W)) u_stall_cnt (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .clr_i  (1'b0),
        .inc_i  (~pc_write),
        .count_o(stall_cnt)
    );

    assign hz.PC_Write    = pc_write;
    assign hz.IFID_Write  = ifid_write;
    assign hz.IFID_Flush  = ifid_flush;
    assign hz.IDEX_Flush  = idex_flush;
    assign hz.IDEX_Write  = idex_write;
    assign hz.EXMEM_Write = exmem_write;
    assign hz.MEMWB_Flush = memwb_flush;
    assign hz.irq_take    = irq_take;
    assign hz.mem_timeout = mem_timeout_q;
    assign hz.stall_count = stall_cnt;
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: RUN-state vector table plus hand-built
// memory-wait, timeout, interrupt-drain and reset sequences.
module tb_hazard_stall_unit;
    // Control word: {PC_Write, IFID_Write, IFID_Flush, IDEX_Flush,
    //                IDEX_Write, EXMEM_Write, MEMWB_Flush, irq_take}
    localparam logic [7:0] CDef    = 8'b1100_1100;
    localparam logic [7:0] CLu     = 8'b0001_1100;
    localparam logic [7:0] CBr     = 8'b1111_1100;
    localparam logic [7:0] CFreeze = 8'b0000_0010;
    localparam logic [7:0] CDrain  = 8'b0110_1100;
    localparam logic [7:0] CIrq    = 8'b1110_1101;
    localparam logic [7:0] CReset  = 8'b0000_0000;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic [4:0] exrd;
        logic       exmr;
        logic       macc;
        logic       drdy;
        logic       br;
        logic [7:0] exp_ctrl;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;
    int   stall_model;
    logic [7:0] ctrl;
    vec_t vecs [10];

    hazard_stall_unit_if #(.CNT_W(16)) bus ();

    hazard_stall_unit #(
        .DRAIN_CYCLES(3),
        .MEM_TIMEOUT (15),
        .CNT_W       (16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .hz   (bus.slave)
    );

    assign ctrl = {bus.PC_Write, bus.IFID_Write, bus.IFID_Flush, bus.IDEX_Flush,
                   bus.IDEX_Write, bus.EXMEM_Write, bus.MEMWB_Flush, bus.irq_take};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_total++;
        if (act === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    // Called just after a negedge with inputs already driven; ends at the next negedge.
    task automatic step_chk(input string nm, input logic [7:0] exp_ctrl);
        #1;
        chk(nm, 32'(ctrl), 32'(exp_ctrl));
        chk({nm, "_cnt"}, 32'(bus.stall_count), 32'(stall_model));
        if (!exp_ctrl[7]) stall_model++;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.ID_rs1          = 5'd0;
        bus.ID_rs2          = 5'd0;
        bus.ID_use_rs1      = 1'b0;
        bus.ID_use_rs2      = 1'b0;
        bus.EX_rd           = 5'd0;
        bus.EX_MemRead      = 1'b0;
        bus.MEM_MemAccess   = 1'b0;
        bus.dmem_ready      = 1'b1;
        bus.EX_branch_taken = 1'b0;
        bus.irq_req         = 1'b0;
    endtask

    initial begin
        n_pass      = 0;
        n_total     = 0;
        stall_model = 0;
        rst_n       = 1'b0;
        idle_inputs();

        //          rs1    rs2    u1 u2  exrd  mr  macc drdy br  expected
        vecs[0] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, CDef};
        vecs[1] = '{5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, CLu};
        vecs[2] = '{5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, CDef};
        vecs[3] = '{5'd0, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, CDef};
        vecs[4] = '{5'd9, 5'd1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, CLu};
        vecs[5] = '{5'd9, 5'd1, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, CDef};
        vecs[6] = '{5'd7, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, CDef};
        vecs[7] = '{5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, CBr};
        vecs[8] = '{5'd3, 5'd4, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1, 1'b1, CBr};
        vecs[9] = '{5'd3, 5'd4, 1'b1, 1'b1, 5'd8, 1'b0, 1'b1, 1'b1, 1'b0, CDef};

        #3;
        chk("reset_ctrl", 32'(ctrl), 32'(CReset));
        chk("reset_cnt", 32'(bus.stall_count), 32'd0);
        chk("reset_timeout", 32'(bus.mem_timeout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            bus.ID_rs1          = vecs[i].rs1;
            bus.ID_rs2          = vecs[i].rs2;
            bus.ID_use_rs1      = vecs[i].use1;
            bus.ID_use_rs2      = vecs[i].use2;
            bus.EX_rd           = vecs[i].exrd;
            bus.EX_MemRead      = vecs[i].exmr;
            bus.MEM_MemAccess   = vecs[i].macc;
            bus.dmem_ready      = vecs[i].drdy;
            bus.EX_branch_taken = vecs[i].br;
            step_chk($sformatf("vec%0d", i), vecs[i].exp_ctrl);
        end
        idle_inputs();

        // Four-cycle memory wait, released by dmem_ready on the fifth.
        bus.MEM_MemAccess = 1'b1;
        bus.dmem_ready    = 1'b0;
        for (int i = 0; i < 4; i++) step_chk($sformatf("mwait%0d", i), CFreeze);
        bus.dmem_ready = 1'b1;
        step_chk("mwait_release", CDef);
        bus.MEM_MemAccess = 1'b0;
        step_chk("mwait_after", CDef);
        chk("mwait_no_timeout", 32'(bus.mem_timeout), 32'd0);

        // dmem_ready never arrives: 15 freeze cycles, forced release, sticky flag.
        bus.MEM_MemAccess = 1'b1;
        bus.dmem_ready    = 1'b0;
        for (int i = 0; i < 15; i++) step_chk($sformatf("tmo%0d", i), CFreeze);
        chk("tmo_flag_before", 32'(bus.mem_timeout), 32'd0);
        step_chk("tmo_release", CDef);
        bus.MEM_MemAccess = 1'b0;
        bus.dmem_ready    = 1'b1;
        step_chk("tmo_after", CDef);
        chk("tmo_flag_set", 32'(bus.mem_timeout), 32'd1);
        step_chk("tmo_idle", CDef);
        chk("tmo_flag_sticky", 32'(bus.mem_timeout), 32'd1);

        // Interrupt from idle: 1 + 3 drain cycles, one irq_take, back to RUN.
        bus.irq_req = 1'b1;
        for (int i = 0; i < 4; i++) step_chk($sformatf("drain%0d", i), CDrain);
        step_chk("irq_take", CIrq);
        bus.irq_req = 1'b0;
        step_chk("irq_after", CDef);

        // Same, with a two-cycle memory freeze in the middle of the drain.
        bus.irq_req = 1'b1;
        step_chk("fdrain0", CDrain);
        step_chk("fdrain1", CDrain);
        bus.MEM_MemAccess = 1'b1;
        bus.dmem_ready    = 1'b0;
        step_chk("fdrain_frz0", CFreeze);
        step_chk("fdrain_frz1", CFreeze);
        bus.MEM_MemAccess = 1'b0;
        bus.dmem_ready    = 1'b1;
        step_chk("fdrain2", CDrain);
        step_chk("fdrain3", CDrain);
        step_chk("firq_take", CIrq);
        bus.irq_req = 1'b0;
        step_chk("firq_after", CDef);

        // Reset asserted mid-drain clears everything; no interrupt afterwards.
        bus.irq_req = 1'b1;
        step_chk("rdrain0", CDrain);
        step_chk("rdrain1", CDrain);
        #1;
        rst_n = 1'b0;
        bus.irq_req = 1'b0;
        #1;
        chk("rst_mid_ctrl", 32'(ctrl), 32'(CReset));
        chk("rst_mid_cnt", 32'(bus.stall_count), 32'd0);
        chk("rst_mid_timeout", 32'(bus.mem_timeout), 32'd0);
        stall_model = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step_chk($sformatf("post_rst%0d", i), CDef);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
